// File: rtl/pum_xbox_row_ctrl_if.sv
// PUM XBOX row port plus narrow crossbar-memory port.
// slave = controller view, master = requester/memory view.
interface pum_xbox_row_ctrl_if #(
  parameter int ROW_W   = 1024,
  parameter int BEAT_W  = 256,
  parameter int ADDR_W  = 14,
  parameter int MADDR_W = ADDR_W + $clog2(ROW_W / BEAT_W)
);
  logic               pum_rd_from_xbox;
  logic               pum_wr_to_xbox;
  logic [ADDR_W-1:0]  pum_xbox_addr;
  logic [ROW_W-1:0]   pum_xbox_wdata;
  logic [ROW_W-1:0]   pum_xbox_rdata;
  logic               pum_xbox_ready;
  logic               pum_xbox_rvalid;
  logic               pum_xbox_wdone;
  logic               pum_xbox_err;
  logic               mem_req;
  logic               mem_we;
  logic [MADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0]  mem_wdata;
  logic               mem_gnt;
  logic               mem_rvalid;
  logic [BEAT_W-1:0]  mem_rdata;

  modport slave (
    input  pum_rd_from_xbox, pum_wr_to_xbox,
    input  pum_xbox_addr, pum_xbox_wdata,
    output pum_xbox_rdata, pum_xbox_ready,
    output pum_xbox_rvalid, pum_xbox_wdone,
    output pum_xbox_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output pum_rd_from_xbox, pum_wr_to_xbox,
    output pum_xbox_addr, pum_xbox_wdata,
    input  pum_xbox_rdata, pum_xbox_ready,
    input  pum_xbox_rvalid, pum_xbox_wdone,
    input  pum_xbox_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/pum_xbox_row_ctrl.sv
// Row-transfer controller: serialises 1024-bit PUM rows into
// narrow crossbar-memory beats and reassembles read beats.
module pum_xbox_row_ctrl #(
  parameter int ROW_W  = 1024,
  parameter int BEAT_W = 256,
  parameter int ADDR_W = 14
) (
  input logic                clk,
  input logic                rst_n,
  pum_xbox_row_ctrl_if.slave bus
);
  localparam int BEATS = ROW_W / BEAT_W;
  localparam int BIW   = $clog2(BEATS);
  localparam logic [BIW-1:0] LAST = BIW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, WR_BEAT, RD_ISSUE, RD_DRAIN, RD_RESP
  } state_t;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [ROW_W-1:0]  r_wdata;
  logic [ROW_W-1:0]  r_rbuf;
  logic [ROW_W-1:0]  r_rdata;
  logic [ROW_W-1:0]  w_rbuf;
  logic [BIW-1:0]    r_wbeat;
  logic [BIW-1:0]    r_ibeat;
  logic [BIW-1:0]    r_rbeat;
  logic              r_rvalid;
  logic              r_wdone;
  logic              r_err;
  logic              w_idle;
  logic              w_acc_rd;
  logic              w_acc_wr;
  logic              w_both;
  logic              w_wgnt;
  logic              w_ignt;
  logic              w_cap;
  logic              w_last_cap;

  assign w_idle   = (r_state == IDLE);
  assign w_acc_rd = w_idle && bus.pum_rd_from_xbox
                    && !bus.pum_wr_to_xbox;
  assign w_acc_wr = w_idle && bus.pum_wr_to_xbox
                    && !bus.pum_rd_from_xbox;
  assign w_both   = w_idle && bus.pum_wr_to_xbox
                    && bus.pum_rd_from_xbox;
  assign w_wgnt   = (r_state == WR_BEAT) && bus.mem_gnt;
  assign w_ignt   = (r_state == RD_ISSUE) && bus.mem_gnt;
  // Beats arriving outside an active read are dropped here.
  assign w_cap    = bus.mem_rvalid
                    && (r_state == RD_ISSUE
                        || r_state == RD_DRAIN);
  assign w_last_cap = w_cap && (r_rbeat == LAST);

  always_comb begin
    w_rbuf = r_rbuf;
    w_rbuf[int'(r_rbeat) * BEAT_W +: BEAT_W] = bus.mem_rdata;
  end

  always_comb begin
    w_next        = r_state;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (r_state)
      IDLE: begin
        if (w_acc_rd)      w_next = RD_ISSUE;
        else if (w_acc_wr) w_next = WR_BEAT;
      end
      WR_BEAT: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {r_addr, r_wbeat};
        bus.mem_wdata =
          r_wdata[int'(r_wbeat) * BEAT_W +: BEAT_W];
        if (w_wgnt && r_wbeat == LAST) w_next = IDLE;
      end
      RD_ISSUE: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {r_addr, r_ibeat};
        if (w_last_cap)
          w_next = RD_RESP;
        else if (w_ignt && r_ibeat == LAST)
          w_next = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (w_last_cap) w_next = RD_RESP;
      end
      RD_RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rbuf   <= '0;
      r_rdata  <= '0;
      r_wbeat  <= '0;
      r_ibeat  <= '0;
      r_rbeat  <= '0;
      r_rvalid <= 1'b0;
      r_wdone  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= w_last_cap;
      r_wdone  <= w_wgnt && (r_wbeat == LAST);
      r_err    <= w_both;
      if (w_acc_rd || w_acc_wr) r_addr <= bus.pum_xbox_addr;
      if (w_acc_wr) r_wdata <= bus.pum_xbox_wdata;
      if (w_idle) begin
        r_wbeat <= '0;
        r_ibeat <= '0;
        r_rbeat <= '0;
      end else begin
        if (w_wgnt) r_wbeat <= r_wbeat + 1'b1;
        if (w_ignt) r_ibeat <= r_ibeat + 1'b1;
        if (w_cap) begin
          r_rbeat <= r_rbeat + 1'b1;
          r_rbuf  <= w_rbuf;
        end
      end
      // Row is published together with the valid pulse.
      if (w_last_cap) r_rdata <= w_rbuf;
    end
  end

  assign bus.pum_xbox_ready  = w_idle;
  assign bus.pum_xbox_rvalid = r_rvalid;
  assign bus.pum_xbox_wdone  = r_wdone;
  assign bus.pum_xbox_err    = r_err;
  assign bus.pum_xbox_rdata  = r_rdata;
endmodule

// File: tb/tb_pum_xbox_row_ctrl.sv
// Directed bench for pum_xbox_row_ctrl with a beat-level
// memory model (grant stalls, read latency, injected beats).
module tb_pum_xbox_row_ctrl;
  localparam int ROW_W  = 1024;
  localparam int BEAT_W = 256;
  localparam int ADDR_W = 14;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pum_xbox_row_ctrl_if #(
    .ROW_W(ROW_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)
  ) ifc ();

  pum_xbox_row_ctrl #(
    .ROW_W(ROW_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc)
  );

  typedef struct {
    int           due;
    logic [255:0] d;
  } rv_t;

  rv_t          rq[$];
  logic [255:0] mem_arr [logic [15:0]];
  bit           stall_mode = 1'b0;
  int           lat = 2;
  int           inj_due = -1;
  int           last_due = 0;
  logic [1023:0] row1, row2, row3, row4;

  // Memory model: grants, stores writes, returns reads in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      rq.delete();
      last_due = 0;
      ifc.mem_gnt    = 1'b0;
      ifc.mem_rvalid = 1'b0;
      ifc.mem_rdata  = '0;
    end else begin
      ifc.mem_rvalid = 1'b0;
      ifc.mem_rdata  = '0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        ifc.mem_rvalid = 1'b1;
        ifc.mem_rdata  = rq[0].d;
        void'(rq.pop_front());
      end else if (inj_due == cyc) begin
        ifc.mem_rvalid = 1'b1;
        ifc.mem_rdata  = {8{32'hDEADBEEF}};
      end
      ifc.mem_gnt = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ifc.mem_req && ifc.mem_gnt) begin
        if (ifc.mem_we) begin
          mem_arr[ifc.mem_addr] = ifc.mem_wdata;
        end else begin
          rv_t e;
          e.due = cyc + lat;
          if (e.due <= last_due) e.due = last_due + 1;
          if (stall_mode) e.due += $urandom_range(0, 2);
          e.d = mem_arr.exists(ifc.mem_addr) ?
                mem_arr[ifc.mem_addr] : '0;
          last_due = e.due;
          rq.push_back(e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_write(input logic [13:0] a,
                          input logic [1023:0] r,
                          output bit ok);
    ok = 1'b0;
    ifc.pum_wr_to_xbox = 1'b1;
    ifc.pum_xbox_addr  = a;
    ifc.pum_xbox_wdata = r;
    tick();
    ifc.pum_wr_to_xbox = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (ifc.pum_xbox_wdone === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic do_read(input logic [13:0] a,
                         output logic [1023:0] r,
                         output bit ok);
    ok = 1'b0;
    r  = '0;
    ifc.pum_rd_from_xbox = 1'b1;
    ifc.pum_xbox_addr    = a;
    tick();
    ifc.pum_rd_from_xbox = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (ifc.pum_xbox_rvalid === 1'b1) begin
        ok = 1'b1;
        r  = ifc.pum_xbox_rdata;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.pum_rd_from_xbox = 1'b0;
    ifc.pum_wr_to_xbox   = 1'b0;
    ifc.pum_xbox_addr    = '0;
    ifc.pum_xbox_wdata   = '0;
    repeat (2) tick();
    checks++;
    if (ifc.pum_xbox_ready !== 1'b1 || ifc.pum_xbox_rvalid !== 1'b0
        || ifc.pum_xbox_wdone !== 1'b0 || ifc.pum_xbox_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: rdy=%b rv=%b wd=%b err=%b want 1 0 0 0",
               ifc.pum_xbox_ready, ifc.pum_xbox_rvalid,
               ifc.pum_xbox_wdone, ifc.pum_xbox_err);
    end
    checks++;
    if (ifc.mem_req !== 1'b0 || ifc.mem_we !== 1'b0
        || ifc.mem_addr !== 16'h0 || ifc.mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem: req=%b we=%b addr=%h want 0 0 0000",
               ifc.mem_req, ifc.mem_we, ifc.mem_addr);
    end
    checks++;
    if (ifc.pum_xbox_rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got nonzero want 0");
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (ifc.pum_xbox_ready !== 1'b1 || ifc.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b req=%b want 1 0",
               ifc.pum_xbox_ready, ifc.mem_req);
    end
  endtask

  task automatic test_write();
    logic [31:0]  w;
    logic [255:0] exp;
    for (int k = 0; k < 4; k++) begin
      w = 32'hA0 + k;
      row1[k*256 +: 256] = {8{w}};
    end
    checks++;
    if (ifc.pum_xbox_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready0: got %b want 1", ifc.pum_xbox_ready);
    end
    ifc.pum_wr_to_xbox = 1'b1;
    ifc.pum_xbox_addr  = 14'h0123;
    ifc.pum_xbox_wdata = row1;
    tick();
    ifc.pum_wr_to_xbox = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w   = 32'hA0 + k;
      exp = {8{w}};
      checks++;
      if (ifc.mem_req !== 1'b1 || ifc.mem_we !== 1'b1
          || ifc.mem_addr !== 16'(16'h048C + k)
          || ifc.mem_wdata !== exp || ifc.pum_xbox_wdone !== 1'b0
          || ifc.pum_xbox_ready !== 1'b0) begin
        errors++;
        $display("FAIL wr_beat%0d: req=%b we=%b addr=%h wd=%h want 1 1 %h %h",
                 k, ifc.mem_req, ifc.mem_we, ifc.mem_addr,
                 ifc.mem_wdata[31:0], 16'(16'h048C + k), w);
      end
      tick();
    end
    checks++;
    if (ifc.pum_xbox_wdone !== 1'b1 || ifc.pum_xbox_ready !== 1'b1
        || ifc.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: wd=%b rdy=%b req=%b want 1 1 0",
               ifc.pum_xbox_wdone, ifc.pum_xbox_ready, ifc.mem_req);
    end
    tick();
    checks++;
    if (ifc.pum_xbox_wdone !== 1'b0) begin
      errors++;
      $display("FAIL wr_done_pulse: got %b want 0", ifc.pum_xbox_wdone);
    end
  endtask

  task automatic test_read_latency();
    bit ok;
    for (int k = 0; k < 32; k++) row2[k*32 +: 32] = 32'h5A000000 + k * 3;
    do_write(14'h3FFF, row2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rd_prewrite: wdone got 0 want 1");
    end
    ifc.pum_rd_from_xbox = 1'b1;
    ifc.pum_xbox_addr    = 14'h3FFF;
    tick();
    ifc.pum_rd_from_xbox = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (ifc.pum_xbox_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rd_early_c%0d: rvalid got 1 want 0", c);
      end
      tick();
    end
    checks++;
    if (ifc.pum_xbox_rvalid !== 1'b1 || ifc.pum_xbox_rdata !== row2
        || ifc.pum_xbox_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_c7: rv=%b rdy=%b data_lo=%h want 1 0 %h",
               ifc.pum_xbox_rvalid, ifc.pum_xbox_ready,
               ifc.pum_xbox_rdata[31:0], row2[31:0]);
    end
    tick();
    checks++;
    if (ifc.pum_xbox_rvalid !== 1'b0 || ifc.pum_xbox_rdata !== row2
        || ifc.pum_xbox_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_hold: rv=%b rdy=%b data_hi=%h want 0 1 %h",
               ifc.pum_xbox_rvalid, ifc.pum_xbox_ready,
               ifc.pum_xbox_rdata[1023:992], row2[1023:992]);
    end
  endtask

  task automatic test_stalls();
    bit            we;
    bit            done;
    bit            stall;
    logic [13:0]   a;
    logic [1023:0] r;
    logic [1023:0] got;
    logic [15:0]   p_addr;
    logic [255:0]  p_wdata;
    int            nb;
    for (int k = 0; k < 32; k++) begin
      row3[k*32 +: 32] = $urandom;
      row4[k*32 +: 32] = $urandom;
    end
    stall_mode = 1'b1;
    for (int op = 0; op < 4; op++) begin
      we  = (op < 2);
      a   = (op % 2 == 0) ? 14'h1555 : 14'h2AAA;
      r   = (op % 2 == 0) ? row3 : row4;
      got = '0;
      ifc.pum_wr_to_xbox   = we;
      ifc.pum_rd_from_xbox = !we;
      ifc.pum_xbox_addr    = a;
      ifc.pum_xbox_wdata   = we ? r : '0;
      tick();
      ifc.pum_wr_to_xbox   = 1'b0;
      ifc.pum_rd_from_xbox = 1'b0;
      nb = 0;
      done = 1'b0;
      stall = 1'b0;
      p_addr = '0;
      p_wdata = '0;
      for (int c = 0; c < 400 && !done; c++) begin
        if (stall) begin
          checks++;
          if (ifc.mem_req !== 1'b1 || ifc.mem_addr !== p_addr
              || ifc.mem_wdata !== p_wdata) begin
            errors++;
            $display("FAIL stall_hold op%0d: req=%b addr=%h want 1 %h",
                     op, ifc.mem_req, ifc.mem_addr, p_addr);
          end
        end
        if (ifc.mem_req === 1'b1 && ifc.mem_gnt === 1'b1) begin
          checks++;
          if (ifc.mem_addr !== {a, nb[1:0]} || ifc.mem_we !== we
              || nb > 3
              || (we && ifc.mem_wdata !== r[nb*256 +: 256])) begin
            errors++;
            $display("FAIL stall_beat op%0d n%0d: addr=%h we=%b want %h %b",
                     op, nb, ifc.mem_addr, ifc.mem_we,
                     {a, nb[1:0]}, we);
          end
          nb++;
        end
        stall   = (ifc.mem_req === 1'b1) && (ifc.mem_gnt !== 1'b1);
        p_addr  = ifc.mem_addr;
        p_wdata = ifc.mem_wdata;
        if (we ? ifc.pum_xbox_wdone === 1'b1
               : ifc.pum_xbox_rvalid === 1'b1) begin
          done = 1'b1;
          got  = ifc.pum_xbox_rdata;
        end
        tick();
      end
      checks++;
      if (!done || nb != 4) begin
        errors++;
        $display("FAIL stall_complete op%0d: done=%b beats=%0d want 1 4",
                 op, done, nb);
      end
      if (!we) begin
        checks++;
        if (got !== r) begin
          errors++;
          $display("FAIL stall_data op%0d: lo=%h want %h",
                   op, got[31:0], r[31:0]);
        end
      end
    end
    stall_mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit            ok;
    logic [1023:0] got;
    do_write(14'h0200, row3, ok);
    checks++;
    if (!ok || ifc.pum_xbox_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_write: ok=%b rdy=%b want 1 1",
               ok, ifc.pum_xbox_ready);
    end
    do_read(14'h0200, got, ok);
    checks++;
    if (!ok || got !== row3) begin
      errors++;
      $display("FAIL b2b_read: ok=%b lo=%h want 1 %h",
               ok, got[31:0], row3[31:0]);
    end
  endtask

  task automatic test_err_busy();
    ifc.pum_rd_from_xbox = 1'b1;
    ifc.pum_wr_to_xbox   = 1'b1;
    ifc.pum_xbox_addr    = 14'h0055;
    tick();
    ifc.pum_rd_from_xbox = 1'b0;
    ifc.pum_wr_to_xbox   = 1'b0;
    checks++;
    if (ifc.pum_xbox_err !== 1'b1 || ifc.mem_req !== 1'b0
        || ifc.pum_xbox_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse: err=%b req=%b rdy=%b want 1 0 1",
               ifc.pum_xbox_err, ifc.mem_req, ifc.pum_xbox_ready);
    end
    tick();
    checks++;
    if (ifc.pum_xbox_err !== 1'b0 || ifc.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL err_once: err=%b req=%b want 0 0",
               ifc.pum_xbox_err, ifc.mem_req);
    end
    ifc.pum_wr_to_xbox = 1'b1;
    ifc.pum_xbox_addr  = 14'h0042;
    ifc.pum_xbox_wdata = row1;
    tick();
    ifc.pum_rd_from_xbox = 1'b1;
    ifc.pum_wr_to_xbox   = 1'b1;
    ifc.pum_xbox_addr    = 14'h3000;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ifc.mem_req !== 1'b1 || ifc.mem_addr !== {14'h0042, 2'(k)}
          || ifc.pum_xbox_err !== 1'b0) begin
        errors++;
        $display("FAIL busy_beat%0d: req=%b addr=%h err=%b want 1 %h 0",
                 k, ifc.mem_req, ifc.mem_addr, ifc.pum_xbox_err,
                 {14'h0042, 2'(k)});
      end
      if (k == 3) begin
        ifc.pum_rd_from_xbox = 1'b0;
        ifc.pum_wr_to_xbox   = 1'b0;
      end
      tick();
    end
    checks++;
    if (ifc.pum_xbox_wdone !== 1'b1 || ifc.pum_xbox_err !== 1'b0) begin
      errors++;
      $display("FAIL busy_done: wd=%b err=%b want 1 0",
               ifc.pum_xbox_wdone, ifc.pum_xbox_err);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (ifc.mem_req !== 1'b0 || ifc.pum_xbox_err !== 1'b0) begin
        errors++;
        $display("FAIL busy_extra c%0d: req=%b err=%b want 0 0",
                 c, ifc.mem_req, ifc.pum_xbox_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit            ok;
    logic [1023:0] got;
    ifc.pum_rd_from_xbox = 1'b1;
    ifc.pum_xbox_addr    = 14'h0777;
    tick();
    ifc.pum_rd_from_xbox = 1'b0;
    tick();
    tick();
    checks++;
    if (ifc.mem_req !== 1'b1 || ifc.mem_addr !== {14'h0777, 2'd2}) begin
      errors++;
      $display("FAIL rstmid_pre: req=%b addr=%h want 1 %h",
               ifc.mem_req, ifc.mem_addr, {14'h0777, 2'd2});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.mem_req !== 1'b0 || ifc.pum_xbox_ready !== 1'b1
        || ifc.pum_xbox_rvalid !== 1'b0 || ifc.pum_xbox_rdata !== '0
        || ifc.mem_addr !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_async: req=%b rdy=%b rv=%b addr=%h want 0 1 0 0000",
               ifc.mem_req, ifc.pum_xbox_ready,
               ifc.pum_xbox_rvalid, ifc.mem_addr);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (ifc.pum_xbox_rvalid !== 1'b0 || ifc.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet c%0d: rv=%b req=%b want 0 0",
                 c, ifc.pum_xbox_rvalid, ifc.mem_req);
      end
    end
    do_read(14'h3FFF, got, ok);
    checks++;
    if (!ok || got !== row2) begin
      errors++;
      $display("FAIL rstmid_after: ok=%b lo=%h want 1 %h",
               ok, got[31:0], row2[31:0]);
    end
  endtask

  task automatic test_spurious();
    bit            ok;
    logic [1023:0] got;
    inj_due = cyc + 1;
    tick();
    tick();
    checks++;
    if (ifc.pum_xbox_rvalid !== 1'b0 || ifc.pum_xbox_rdata !== row2
        || ifc.pum_xbox_ready !== 1'b1) begin
      errors++;
      $display("FAIL spur_idle: rv=%b rdy=%b lo=%h want 0 1 %h",
               ifc.pum_xbox_rvalid, ifc.pum_xbox_ready,
               ifc.pum_xbox_rdata[31:0], row2[31:0]);
    end
    ifc.pum_rd_from_xbox = 1'b1;
    ifc.pum_xbox_addr    = 14'h0123;
    inj_due = cyc + 7;
    tick();
    ifc.pum_rd_from_xbox = 1'b0;
    repeat (6) tick();
    checks++;
    if (ifc.pum_xbox_rvalid !== 1'b1 || ifc.pum_xbox_rdata !== row1) begin
      errors++;
      $display("FAIL spur_read: rv=%b lo=%h want 1 %h",
               ifc.pum_xbox_rvalid, ifc.pum_xbox_rdata[31:0], row1[31:0]);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ifc.pum_xbox_rvalid !== 1'b0 || ifc.pum_xbox_rdata !== row1) begin
        errors++;
        $display("FAIL spur_fifth c%0d: rv=%b lo=%h want 0 %h",
                 c, ifc.pum_xbox_rvalid, ifc.pum_xbox_rdata[31:0],
                 row1[31:0]);
      end
    end
    inj_due = -1;
    do_read(14'h3FFF, got, ok);
    checks++;
    if (!ok || got !== row2) begin
      errors++;
      $display("FAIL spur_next: ok=%b lo=%h want 1 %h",
               ok, got[31:0], row2[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_latency();
    test_stalls();
    test_back_to_back();
    test_err_busy();
    test_reset_mid();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
